shot_pixel_gen: RTL
===================

Name: shot_pixel_gen

Overview:
Pixel-colour stage sitting directly downstream of the VGA sync generator. It consumes pixel_x/pixel_y/video_on/hsync/vsync and renders the basketball scene: sky, floor, backboard, rim and a circular ball. Ball position arrives from the physics block through a one-entry valid/ready buffer and is applied only at the start of vertical blanking, so frames never tear. Output RGB and syncs are pipelined and mutually aligned for the 12-bit VGA DAC.

Parameters:
BALL_R, 8, ball radius in pixels (1..31)
BALL_X0, 100, ball centre x after reset
BALL_Y0, 400, ball centre y after reset
HOOP_X, 560, left x of rim
HOOP_Y, 160, y of rim row (rim is 3 px tall: HOOP_Y..HOOP_Y+2)
HOOP_W, 40, rim width in pixels
BOARD_X, 600, left x of backboard (8 px wide, spans HOOP_Y-60..HOOP_Y+10)
FLOOR_Y, 440, first floor row
C_SKY, 12'h6AF, sky colour; C_FLOOR, 12'hA62; C_BOARD, 12'hFFF; C_RIM, 12'hF00; C_BALL, 12'hF80

Ports:
clk  in  1  pixel clock (25 MHz, one pixel per cycle)
reset  in  1  synchronous, active-low reset
video_on  in  1  active-area flag from sync generator
hsync_in  in  1  registered hsync from sync generator
vsync_in  in  1  registered vsync from sync generator
pixel_x  in  10  current column
pixel_y  in  10  current row
ball_x  in  10  requested ball centre x
ball_y  in  10  requested ball centre y
ball_valid  in  1  ball_x/ball_y valid
ball_ready  out  1  pending buffer empty, can accept
frame_tick  out  1  one-cycle pulse at frame boundary
rgb  out  12  4:4:4 colour to DAC
hsync  out  1  hsync aligned with rgb
vsync  out  1  vsync aligned with rgb

Behaviour:
- One clock; reset is synchronous and active-low, sampled on rising clk. While reset low: rgb=0, hsync=0, vsync=0, frame_tick=0, ball_ready=1, pending empty, active position = (BALL_X0, BALL_Y0), all pipeline regs 0.
- Frame boundary: the cycle where pixel_x==0 and pixel_y==480. frame_tick is registered: high exactly one cycle, the cycle after the boundary is sampled. Once per frame.
- Position buffer: accept when ball_valid && ball_ready. ball_ready = !pending_full.
  - Accept on non-boundary cycle -> pending <= input, pending_full <= 1, ball_ready low from the next cycle.
  - Boundary with pending_full -> active <= pending, pending_full <= 0; ready is 1 next cycle.
  - Boundary with pending empty and accept in same cycle -> bypass: active <= input directly, pending stays empty.
  - Boundary, nothing pending -> active unchanged.
  - ball_valid while ready low is ignored; the source must hold.
- Pipeline, latency 2 for rgb/hsync/vsync (all equal delay):
  - S1 registers: dx = pixel_x - active_x, dy = pixel_y - active_y (11-bit signed), region flags (rim, board, floor), video_on, hsync_in, vsync_in.
  - S2: d2 = dx*dx + dy*dy (22-bit unsigned, no overflow); in_ball = d2 <= BALL_R*BALL_R. Colour priority ball > rim > board > floor > sky. rgb registered; rgb=0 when the delayed video_on is 0.
- Region rules: rim = HOOP_X <= x < HOOP_X+HOOP_W and HOOP_Y <= y <= HOOP_Y+2. Board = BOARD_X <= x < BOARD_X+8 and HOOP_Y-60 <= y <= HOOP_Y+10. Floor = y >= FLOOR_Y.
- Ball partly off-screen (centre near 0 or up to 1023): signed dx/dy clip correctly, with no wrap artefacts on the opposite edge.
- Active position changes only at boundaries; mid-frame pixels always use one consistent position.
- Reset mid-frame: outputs go to their reset values the next cycle. The first frame_tick after reset comes at the next boundary.

Test Plan:
- Reset low 3 cycles then high, pixel (0,0) video_on=1 -> rgb=0 during reset; 2 cycles after reset release rgb=C_SKY (12'h6AF); ball_ready=1.
- Default ball, scan row 400 -> rgb=C_BALL for x=92..108, sky at x=91 and x=109; rgb at output lags pixel_x by exactly 2 cycles, hsync_in edge also lags 2.
- ball_valid with (300,200) at row 100 -> ball_ready drops the next cycle; ball still drawn at (100,400) for the rest of the frame; frame_tick at row 480; next frame draws at (300,200); ready returns to 1.
- ball_valid with (50,50) exactly on the boundary cycle, pending empty -> bypass; next frame ball at (50,50); ball_ready stays 1 throughout.
- Ball at (2,300), row 300 -> x=0..10 ball colour, x=1020+ never ball; pixel (570,161) -> C_RIM; (603,130) -> C_BOARD; (10,450) -> C_FLOOR; video_on=0 -> rgb=0.
- Reset asserted mid-frame with pending_full=1 -> pending cleared, ball_ready=1, active returns to (100,400), frame_tick does not pulse until the next boundary.

Source files
------------

// File: rtl/shot_pixel_gen.sv
// Basketball scene pixel-colour stage: ball/rim/board/floor/sky rendering with a
// one-entry ball-position buffer applied at the frame boundary, 2-cycle aligned output.
module shot_pixel_gen #(
    parameter int BALL_R  = 8,
    parameter int BALL_X0 = 100,
    parameter int BALL_Y0 = 400,
    parameter int HOOP_X  = 560,
    parameter int HOOP_Y  = 160,
    parameter int HOOP_W  = 40,
    parameter int BOARD_X = 600,
    parameter int FLOOR_Y = 440,
    parameter logic [11:0] C_SKY   = 12'h6AF,
    parameter logic [11:0] C_FLOOR = 12'hA62,
    parameter logic [11:0] C_BOARD = 12'hFFF,
    parameter logic [11:0] C_RIM   = 12'hF00,
    parameter logic [11:0] C_BALL  = 12'hF80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       ball_valid,
    output logic       ball_ready,
    output logic       frame_tick,
    output logic [11:0] rgb,
    output logic       hsync,
    output logic       vsync
);

    localparam logic [9:0]  RST_X     = 10'(BALL_X0);
    localparam logic [9:0]  RST_Y     = 10'(BALL_Y0);
    localparam logic [9:0]  RIM_X_LO  = 10'(HOOP_X);
    localparam logic [9:0]  RIM_X_HI  = 10'(HOOP_X + HOOP_W);
    localparam logic [9:0]  RIM_Y_LO  = 10'(HOOP_Y);
    localparam logic [9:0]  RIM_Y_HI  = 10'(HOOP_Y + 2);
    localparam logic [9:0]  BRD_X_LO  = 10'(BOARD_X);
    localparam logic [9:0]  BRD_X_HI  = 10'(BOARD_X + 8);
    localparam logic [9:0]  BRD_Y_LO  = 10'(HOOP_Y - 60);
    localparam logic [9:0]  BRD_Y_HI  = 10'(HOOP_Y + 10);
    localparam logic [9:0]  FLR_Y     = 10'(FLOOR_Y);
    localparam logic [21:0] R_SQ      = 22'(BALL_R * BALL_R);

    // Handshake: a position transfers on any cycle where ball_valid && ball_ready;
    // ball_ready is high exactly when the pending slot is empty, and a source
    // seeing ball_ready low must hold ball_x/ball_y/ball_valid unchanged.
    logic        boundary;
    logic        accept;

    logic        pending_full_q, pending_full_d;
    logic [9:0]  pending_x_q, pending_x_d;
    logic [9:0]  pending_y_q, pending_y_d;
    logic [9:0]  active_x_q, active_x_d;
    logic [9:0]  active_y_q, active_y_d;
    logic        frame_tick_q, frame_tick_d;

    logic signed [10:0] dx_q, dx_d;
    logic signed [10:0] dy_q, dy_d;
    logic        rim_q, rim_d;
    logic        board_q, board_d;
    logic        floor_q, floor_d;
    logic        von1_q, von1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;

    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;

    logic [9:0]  adx, ady;
    logic [19:0] sq_x, sq_y;
    logic [21:0] d2;
    logic        in_ball;

    always_comb begin
        boundary       = (pixel_x == 10'd0) && (pixel_y == 10'd480);
        accept         = ball_valid && !pending_full_q;

        pending_full_d = pending_full_q;
        pending_x_d    = pending_x_q;
        pending_y_d    = pending_y_q;
        active_x_d     = active_x_q;
        active_y_d     = active_y_q;

        // Boundary with an empty slot lets a same-cycle request go straight to active.
        if (boundary) begin
            if (pending_full_q) begin
                active_x_d     = pending_x_q;
                active_y_d     = pending_y_q;
                pending_full_d = 1'b0;
            end else if (accept) begin
                active_x_d = ball_x;
                active_y_d = ball_y;
            end
        end else if (accept) begin
            pending_x_d    = ball_x;
            pending_y_d    = ball_y;
            pending_full_d = 1'b1;
        end
        frame_tick_d = boundary;

        // Stage 1: signed offsets keep partly off-screen balls from wrapping.
        dx_d    = $signed({1'b0, pixel_x}) - $signed({1'b0, active_x_q});
        dy_d    = $signed({1'b0, pixel_y}) - $signed({1'b0, active_y_q});
        rim_d   = (pixel_x >= RIM_X_LO) && (pixel_x < RIM_X_HI) &&
                  (pixel_y >= RIM_Y_LO) && (pixel_y <= RIM_Y_HI);
        board_d = (pixel_x >= BRD_X_LO) && (pixel_x < BRD_X_HI) &&
                  (pixel_y >= BRD_Y_LO) && (pixel_y <= BRD_Y_HI);
        floor_d = (pixel_y >= FLR_Y);
        von1_d  = video_on;
        hs1_d   = hsync_in;
        vs1_d   = vsync_in;

        // Stage 2: squared distance via magnitudes; max 2*1023^2 fits in 22 bits.
        adx     = dx_q[10] ? 10'(-dx_q) : dx_q[9:0];
        ady     = dy_q[10] ? 10'(-dy_q) : dy_q[9:0];
        sq_x    = {10'd0, adx} * {10'd0, adx};
        sq_y    = {10'd0, ady} * {10'd0, ady};
        d2      = {2'b00, sq_x} + {2'b00, sq_y};
        in_ball = (d2 <= R_SQ);

        if (!von1_q)      rgb_d = 12'h000;
        else if (in_ball) rgb_d = C_BALL;
        else if (rim_q)   rgb_d = C_RIM;
        else if (board_q) rgb_d = C_BOARD;
        else if (floor_q) rgb_d = C_FLOOR;
        else              rgb_d = C_SKY;
        hsync_d = hs1_q;
        vsync_d = vs1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_full_q <= 1'b0;
            pending_x_q    <= 10'd0;
            pending_y_q    <= 10'd0;
            active_x_q     <= RST_X;
            active_y_q     <= RST_Y;
            frame_tick_q   <= 1'b0;
            dx_q           <= 11'sd0;
            dy_q           <= 11'sd0;
            rim_q          <= 1'b0;
            board_q        <= 1'b0;
            floor_q        <= 1'b0;
            von1_q         <= 1'b0;
            hs1_q          <= 1'b0;
            vs1_q          <= 1'b0;
            rgb_q          <= 12'h000;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
        end else begin
            pending_full_q <= pending_full_d;
            pending_x_q    <= pending_x_d;
            pending_y_q    <= pending_y_d;
            active_x_q     <= active_x_d;
            active_y_q     <= active_y_d;
            frame_tick_q   <= frame_tick_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            rim_q          <= rim_d;
            board_q        <= board_d;
            floor_q        <= floor_d;
            von1_q         <= von1_d;
            hs1_q          <= hs1_d;
            vs1_q          <= vs1_d;
            rgb_q          <= rgb_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
        end
    end

    assign ball_ready = !pending_full_q;
    assign frame_tick = frame_tick_q;
    assign rgb        = rgb_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;

endmodule
